// File: rtl/rr_pipeline_arbiter.sv
// Round-robin arbiter feeding a single registered output stage with valid/ready handshake.
// Define RR_ARB_SRC_ID_EN to add the out_src port carrying the winning requester index.
module rr_pipeline_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef RR_ARB_SRC_ID_EN
  ,
  output logic [$clog2(NUM_REQ)-1:0]    out_src
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      ptr_next;
  logic [NUM_REQ-1:0]    grant;
  logic                  found;
  logic                  accept;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p0;

  // Requester index at offset k from base, wrapped modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rot_idx(ptr, k)]) begin
        found     = 1'b1;
        grant_idx = rot_idx(ptr, k);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign accept    = !vld_p0 || out_ready;
  assign req_ready = (accept && !reset) ? grant : '0;
  assign transfer  = |req_ready;
  assign sel_data  = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Output stage p0: a transfer overwrites the word, a pop without transfer empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ptr     <= '0;
    end else if (transfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= sel_data;
      ptr     <= ptr_next;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

`ifdef RR_ARB_SRC_ID_EN
  logic [PTR_W-1:0] src_p0;

  always_ff @(posedge clk) begin
    if (reset)         src_p0 <= '0;
    else if (transfer) src_p0 <= grant_idx;
  end

  assign out_src = src_p0;
`endif

  assign out_data  = data_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_rr_pipeline_arbiter.sv
// Scoreboard bench for rr_pipeline_arbiter: a queue-based reference model predicts words,
// and a separate monitor compares each presented word against the queue head.
module tb_rr_pipeline_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef RR_ARB_SRC_ID_EN
  logic [1:0]    out_src;
`endif

  rr_pipeline_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk),
    .reset(reset),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef RR_ARB_SRC_ID_EN
    ,
    .out_src(out_src)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_d[$];
  int            exp_s[$];
  bit            m_valid = 1'b0;
  int            m_ptr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the reference model decides who should win this cycle.
  task automatic cycle(input bit rst, input logic [NR-1:0] vld, input logic [NR*DW-1:0] data,
                       input bit ordy);
    int g;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    reset = rst; req_valid = vld; req_data = data; out_ready = ordy;
    #1;
    if (rst) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      exp_d.delete();
      exp_s.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      g = -1;
      if (!m_valid || ordy)
        for (int k = 0; k < NR; k++)
          if (g < 0 && vld[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        exp_d.push_back(data[g*DW +: DW]);
        exp_s.push_back(g);
        m_ptr   = (g + 1) % NR;
        m_valid = 1'b1;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: whenever a word is on the output, it must be the oldest predicted one.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_d.size() == 0) begin
        chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_d[0]));
`ifdef RR_ARB_SRC_ID_EN
        chk("out_src", 32'(out_src), 32'(exp_s[0]));
`endif
        if (out_ready) begin
          void'(exp_d.pop_front());
          void'(exp_s.pop_front());
        end
      end
    end
  end

  logic [NR*DW-1:0] words;
  logic [NR*DW-1:0] rnd_data;

  initial begin
    reset = 1'b1; req_valid = '1; req_data = 32'h4332_2110; out_ready = 1'b1;
    @(posedge clk);
    // Reset held two cycles with everyone requesting.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 4'b1111, 32'h4332_2110, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
    end
    // Rotation: first grant requester 0, then 1,2,3,0 back-to-back.
    words = 32'h4332_2110;
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1111, words, 1'b1);
    // Backpressure for 3 cycles, then release.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1111, words, 1'b0);
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, words, 1'b1);
    // Drain, then set ptr=2 by a lone transfer from requester 1.
    cycle(1'b0, 4'b0000, words, 1'b1);
    cycle(1'b0, 4'b0000, words, 1'b1);
    cycle(1'b1, 4'b0000, words, 1'b1);
    cycle(1'b0, 4'b0010, 32'h0000_A100, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1010, 32'hB300_A100, 1'b1);
    cycle(1'b0, 4'b0000, words, 1'b1);
    // Mid-operation reset while 0x55 is stalled.
    cycle(1'b0, 4'b0001, 32'h0000_0055, 1'b0);
    cycle(1'b0, 4'b0000, 32'h0000_0055, 1'b0);
    chk("hold_55", 32'(out_data), 32'h55);
    cycle(1'b1, 4'b0000, 32'h0000_0055, 1'b0);
    cycle(1'b0, 4'b0000, 32'h0000_0055, 1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 4'b0000, 32'h0000_0055, 1'b1);
    // Requester 2 alone sends 0x7E.
    cycle(1'b0, 4'b0100, 32'h007E_0000, 1'b1);
    cycle(1'b0, 4'b0000, 32'h007E_0000, 1'b1);
    chk("src2_data", 32'(out_data), 32'h7E);
`ifdef RR_ARB_SRC_ID_EN
    chk("src2_idx", 32'(out_src), 32'd2);
`endif
    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rnd_data = {$urandom, $urandom};
      cycle(($urandom_range(63) == 0), NR'($urandom), rnd_data, ($urandom_range(9) < 7));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, words, 1'b1);
    chk("queue_drained", 32'(exp_d.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
